// File: rtl/multi_pulse_stretcher.sv
// Multi-channel pulse stretcher.
// Each channel turns an asserted input into a registered output that stays high for
// HOLD_TICKS clock cycles. It can run in one of two modes:
//   - retriggerable: the hold restarts on every high sample.
//   - one-shot: the hold has a fixed length and the input is ignored while active.
// A per-channel clear aborts the hold. A one-cycle done strobe marks each expiry.
//
// Ports:
//   clk_100Hz     tick clock, rising edge
//   rst_n         asynchronous active-low reset
//   sig_in_i      per-channel raw input, synchronous to clk_100Hz
//   retrig_i      per-channel mode: 1 = retriggerable, 0 = one-shot
//   clear_i       per-channel synchronous abort (no done strobe)
//   stretched_o   per-channel stretched output (registered)
//   done_o        per-channel one-cycle strobe on hold expiry (registered)
//   any_active_o  OR of all stretched outputs
module multi_pulse_stretcher #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned HOLD_TICKS = 100,
  parameter int unsigned CNT_W      = 7
) (
  input  logic              clk_100Hz,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] sig_in_i,
  input  logic [NUM_CH-1:0] retrig_i,
  input  logic [NUM_CH-1:0] clear_i,
  output logic [NUM_CH-1:0] stretched_o,
  output logic [NUM_CH-1:0] done_o,
  output logic              any_active_o
);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  // Count value on the final cycle of a hold.
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(HOLD_TICKS - 1);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             str_q, str_d;
    logic             done_q, done_d;

    // Priority: clear > retrigger restart > expiry > count.
    // A retriggerable channel restarts before it can expire, so a high input
    // never lets it reach expiry.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      str_d   = str_q;
      done_d  = 1'b0;
      if (clear_i[g]) begin
        state_d = StIdle;
        cnt_d   = '0;
        str_d   = 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (sig_in_i[g]) begin
              state_d = StActive;
              cnt_d   = '0;
              str_d   = 1'b1;
            end
          end
          StActive: begin
            if (retrig_i[g] && sig_in_i[g]) begin
              cnt_d = '0;
            end else if (cnt_q == LastCnt) begin
              // A one-shot channel expires even with the input high. It then
              // re-arms from idle on the next edge, which gives one low cycle.
              state_d = StIdle;
              cnt_d   = '0;
              str_d   = 1'b0;
              done_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          default: begin
            state_d = StIdle;
            cnt_d   = '0;
            str_d   = 1'b0;
          end
        endcase
      end
    end

    always_ff @(posedge clk_100Hz or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= StIdle;
        cnt_q   <= '0;
        str_q   <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        str_q   <= str_d;
        done_q  <= done_d;
      end
    end

    assign stretched_o[g] = str_q;
    assign done_o[g]      = done_q;
  end : g_ch

  assign any_active_o = |stretched_o;

endmodule

// File: tb/tb_multi_pulse_stretcher.sv
// Self-checking bench for multi_pulse_stretcher.
// The reference model tracks the number of high cycles still remaining on each channel.
module tb_multi_pulse_stretcher;
  localparam int unsigned NumCh = 4;
  localparam int unsigned Hold  = 100;
  localparam int unsigned CntW  = 7;

  logic             clk_100Hz = 1'b0;
  logic             rst_n     = 1'b0;
  logic [NumCh-1:0] sig_in_i  = '0;
  logic [NumCh-1:0] retrig_i  = '0;
  logic [NumCh-1:0] clear_i   = '0;
  logic [NumCh-1:0] stretched_o;
  logic [NumCh-1:0] done_o;
  logic             any_active_o;

  int total  = 0;
  int passed = 0;

  // Model: rem = high cycles still owed (including the current one), 0 = low.
  int rem [NumCh];
  bit mdone [NumCh];

  multi_pulse_stretcher #(
    .NUM_CH     (NumCh),
    .HOLD_TICKS (Hold),
    .CNT_W      (CntW)
  ) dut (
    .clk_100Hz    (clk_100Hz),
    .rst_n        (rst_n),
    .sig_in_i     (sig_in_i),
    .retrig_i     (retrig_i),
    .clear_i      (clear_i),
    .stretched_o  (stretched_o),
    .done_o       (done_o),
    .any_active_o (any_active_o)
  );

  always #5 clk_100Hz = ~clk_100Hz;

  task automatic model_reset();
    for (int c = 0; c < NumCh; c++) begin
      rem[c]   = 0;
      mdone[c] = 1'b0;
    end
  endtask

  // Advance one clock edge, update the model from the inputs sampled at that edge,
  // then return at the falling edge.
  task automatic tick();
    @(posedge clk_100Hz);
    for (int c = 0; c < NumCh; c++) begin
      mdone[c] = 1'b0;
      if (!rst_n || clear_i[c]) rem[c] = 0;
      else if (rem[c] == 0) begin
        if (sig_in_i[c]) rem[c] = Hold;
      end else if (retrig_i[c] && sig_in_i[c]) rem[c] = Hold;
      else if (rem[c] == 1) begin
        rem[c]   = 0;
        mdone[c] = 1'b1;
      end else rem[c] = rem[c] - 1;
    end
    @(negedge clk_100Hz);
  endtask

  function automatic logic [2*NumCh:0] expected();
    logic [NumCh-1:0] s, d;
    for (int c = 0; c < NumCh; c++) begin
      s[c] = (rem[c] > 0);
      d[c] = mdone[c];
    end
    return {d, s, |s};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if ({done_o, stretched_o, any_active_o} !== '0)
      $display("FAIL reset_state: got %b want 0", {done_o, stretched_o, any_active_o});
    else passed++;
    @(negedge clk_100Hz);
    rst_n = 1'b1;
    @(negedge clk_100Hz);
  endtask

  task automatic test_single_pulse();
    int highs = 0, done_t = -1, others = 0;
    retrig_i = '1;
    for (int i = 0; i < 106; i++) begin
      sig_in_i[0] = (i == 0);
      tick();
      total++;
      if ({done_o, stretched_o, any_active_o} !== expected())
        $display("FAIL single_pulse t=%0d: got %b want %b", i + 1,
                 {done_o, stretched_o, any_active_o}, expected());
      else passed++;
      if (stretched_o[0]) highs++;
      if (done_o[0]) done_t = i + 1;
      if (stretched_o[NumCh-1:1] != '0 || done_o[NumCh-1:1] != '0) others++;
    end
    total++;
    if (highs != 100 || done_t != 101 || others != 0)
      $display("FAIL single_pulse_summary: got highs=%0d done_t=%0d others=%0d want 100 101 0",
               highs, done_t, others);
    else passed++;
  endtask

  task automatic test_retrig();
    int first = -1, last = -1, ndone = 0, done_t = -1;
    retrig_i[1] = 1'b1;
    for (int i = 0; i < 160; i++) begin
      sig_in_i[1] = (i == 0 || i == 50);
      tick();
      total++;
      if ({done_o, stretched_o, any_active_o} !== expected())
        $display("FAIL retrig t=%0d: got %b want %b", i + 1,
                 {done_o, stretched_o, any_active_o}, expected());
      else passed++;
      if (stretched_o[1]) begin
        if (first < 0) first = i + 1;
        last = i + 1;
      end
      if (done_o[1]) begin
        ndone++;
        done_t = i + 1;
      end
    end
    total++;
    if (first != 1 || last != 150 || ndone != 1 || done_t != 151)
      $display("FAIL retrig_summary: got %0d..%0d done %0dx@%0d want 1..150 done 1x@151",
               first, last, ndone, done_t);
    else passed++;
  endtask

  task automatic test_oneshot();
    int highs = 0, ndone = 0, done_t = -1;
    retrig_i[2] = 1'b0;
    for (int i = 0; i < 110; i++) begin
      sig_in_i[2] = (i == 0 || i == 50);
      tick();
      total++;
      if ({done_o, stretched_o, any_active_o} !== expected())
        $display("FAIL oneshot t=%0d: got %b want %b", i + 1,
                 {done_o, stretched_o, any_active_o}, expected());
      else passed++;
      if (stretched_o[2]) highs++;
      if (done_o[2]) begin
        ndone++;
        done_t = i + 1;
      end
    end
    total++;
    if (highs != 100 || ndone != 1 || done_t != 101)
      $display("FAIL oneshot_summary: got highs=%0d done %0dx@%0d want 100 1x@101",
               highs, ndone, done_t);
    else passed++;
  endtask

  task automatic test_const_high();
    int highs = 0, ndone = 0;
    retrig_i[3] = 1'b0;
    for (int i = 0; i < 310; i++) begin
      sig_in_i[3] = (i < 250);
      tick();
      total++;
      if ({done_o, stretched_o, any_active_o} !== expected())
        $display("FAIL const_high t=%0d: got %b want %b", i + 1,
                 {done_o, stretched_o, any_active_o}, expected());
      else passed++;
      if (stretched_o[3]) highs++;
      if (done_o[3]) ndone++;
    end
    total++;
    if (highs != 300 || ndone != 3)
      $display("FAIL const_high_summary: got highs=%0d dones=%0d want 300 3", highs, ndone);
    else passed++;
  endtask

  task automatic test_clear();
    int ndone = 0;
    retrig_i[0] = 1'b1;
    for (int i = 0; i < 60; i++) begin
      sig_in_i[0] = (i == 0 || i == 40);
      clear_i[0]  = (i == 40);
      tick();
      total++;
      if ({done_o, stretched_o, any_active_o} !== expected())
        $display("FAIL clear t=%0d: got %b want %b", i + 1,
                 {done_o, stretched_o, any_active_o}, expected());
      else passed++;
      if (i >= 40 && done_o[0]) ndone++;
      if (i == 40) begin
        total++;
        if (stretched_o[0] !== 1'b0)
          $display("FAIL clear_edge: got stretched=%b want 0", stretched_o[0]);
        else passed++;
      end
    end
    clear_i = '0;
    total++;
    if (ndone != 0) $display("FAIL clear_no_done: got %0d strobes want 0", ndone);
    else passed++;
  endtask

  task automatic test_reset_midhold();
    int highs = 0, done_t = -1;
    retrig_i = 4'b0101;
    for (int i = 0; i < 30; i++) begin
      sig_in_i = (i == 0) ? '1 : '0;
      tick();
    end
    total++;
    if (stretched_o !== '1 || any_active_o !== 1'b1)
      $display("FAIL midhold_pre: got %b/%b want 1111/1", stretched_o, any_active_o);
    else passed++;
    rst_n = 1'b0;
    #1;
    total++;
    if ({done_o, stretched_o, any_active_o} !== '0)
      $display("FAIL midhold_async: got %b want 0", {done_o, stretched_o, any_active_o});
    else passed++;
    for (int i = 0; i < 3; i++) tick();
    total++;
    if ({done_o, stretched_o, any_active_o} !== expected())
      $display("FAIL midhold_held: got %b want %b", {done_o, stretched_o, any_active_o},
               expected());
    else passed++;
    rst_n = 1'b1;
    retrig_i[0] = 1'b1;
    for (int i = 0; i < 106; i++) begin
      sig_in_i[0] = (i == 0);
      tick();
      total++;
      if ({done_o, stretched_o, any_active_o} !== expected())
        $display("FAIL post_reset t=%0d: got %b want %b", i + 1,
                 {done_o, stretched_o, any_active_o}, expected());
      else passed++;
      if (stretched_o[0]) highs++;
      if (done_o[0]) done_t = i + 1;
    end
    total++;
    if (highs != 100 || done_t != 101)
      $display("FAIL post_reset_summary: got highs=%0d done_t=%0d want 100 101", highs, done_t);
    else passed++;
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NumCh; c++) begin
        sig_in_i[c] = ($urandom_range(0, 7) == 0);
        clear_i[c]  = ($urandom_range(0, 79) == 0);
        if ($urandom_range(0, 199) == 0) retrig_i[c] = ~retrig_i[c];
      end
      tick();
      total++;
      if ({done_o, stretched_o, any_active_o} !== expected()) begin
        errs++;
        if (errs < 10)
          $display("FAIL random t=%0d: got %b want %b", i,
                   {done_o, stretched_o, any_active_o}, expected());
      end else passed++;
    end
    sig_in_i = '0;
    clear_i  = '0;
  endtask

  initial begin
    model_reset();
    @(negedge clk_100Hz);
    test_reset();
    test_single_pulse();
    test_retrig();
    test_oneshot();
    test_const_high();
    test_clear();
    test_reset_midhold();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
